// File: rtl/demux_rr_dispatch.sv
// Round-robin 1-to-4 dispatcher: each accepted word goes to the next lane in
// strict order 0,1,2,3 and is held in that lane's register until its consumer takes it.
module demux_rr_dispatch #(
  parameter int BITS  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BITS-1:0]  out0,
  output logic [BITS-1:0]  out1,
  output logic [BITS-1:0]  out2,
  output logic [BITS-1:0]  out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int LANES = 4;
  localparam int PTR_W = 2;

  logic [PTR_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [LANES-1:0] lane_full;
  logic [BITS-1:0]  lane_dat [LANES];
  logic             accept;

  // The pointed-at lane can take a word if it is empty or emptying this cycle;
  // later lanes are never used out of turn, which keeps word order intact.
  assign in_ready = ~lane_full[sel_q] | out_ready[sel_q];
  assign accept   = in_valid & in_ready;

  always_comb begin
    sel_d     = sel_q;
    acc_cnt_d = acc_cnt_q;
    if (accept) begin
      sel_d     = sel_q + PTR_W'(1);
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      acc_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic            fill;
    logic            drain;
    logic            full_d, full_q;
    logic [BITS-1:0] dat_d, dat_q;

    // A same-cycle fill and drain keeps the lane full with the new word.
    always_comb begin
      fill   = accept & (sel_q == PTR_W'(i));
      drain  = full_q & out_ready[i];
      full_d = fill | (full_q & ~drain);
      dat_d  = fill ? in_data : dat_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        full_q <= 1'b0;
        dat_q  <= '0;
      end else begin
        full_q <= full_d;
        dat_q  <= dat_d;
      end
    end

    assign lane_full[i] = full_q;
    assign lane_dat[i]  = dat_q;
  end

  assign out_valid = lane_full;
  assign out0      = lane_dat[0];
  assign out1      = lane_dat[1];
  assign out2      = lane_dat[2];
  assign out3      = lane_dat[3];
  assign sel       = sel_q;
  assign acc_cnt   = acc_cnt_q;

endmodule
